queue_arbiter: RTL and testbench
================================

# queue_arbiter

Round-robin write-side arbiter that shares the single input port of a queue between NumPorts producers using the codebase REQ/ACK handshake. The producer side uses ACK for "data valid"; the queue side uses REQ for "space available". An owner keeps the grant for bursts of up to MaxBurst words. The block sits between producer engines and the queue's dInREQ/dInACK/dIN port, in the queue's write-clock domain.

## Interface
- BitWidth, 32, data word width
- NumPorts, 4, number of producers (2..16)
- MaxBurst, 4, maximum consecutive transfers per grant (>=1)

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- srcACK  in  NumPorts  per-producer "word valid"
- srcDIN  in  NumPorts*BitWidth  producer data, port i at bits [i*BitWidth +: BitWidth]
- srcREQ  out  NumPorts  per-producer "word accepted this cycle if ACK high"
- qREQ  in  1  queue has space (queue dInREQ)
- qACK  out  1  word valid to queue (queue dInACK)
- qDIN  out  BitWidth  word to queue (queue dIN)
- GrantIdx  out  max(1,$clog2(NumPorts))  current owner index
- Busy  out  1  an owner is granted

## Operation
- Registered state:
  - State: IDLE or GRANT.
  - Owner: the current owner index.
  - LastIdx: the most recently granted index.
  - BurstCnt: $clog2(MaxBurst+1) bits.
- Round-robin pick:
  - Scan from (LastIdx+1) mod NumPorts upward with wrap.
  - Choose the first i with srcACK[i]=1.
  - The scan includes LastIdx itself as the final candidate.
- IDLE:
  - All srcREQ=0, qACK=0, qDIN=0, Busy=0.
  - If any srcACK is high: next State=GRANT, Owner=pick, LastIdx=pick, BurstCnt=0.
- GRANT (combinational path through the owner):
  - srcREQ[Owner]=qREQ; all other srcREQ=0.
  - qACK=srcACK[Owner].
  - qDIN=srcDIN[Owner].
  - Busy=1, GrantIdx=Owner.
- Transfer: xfer = qREQ && srcACK[Owner]. On xfer, BurstCnt increments.
- Release occurs in GRANT when either condition holds:
  - (a) xfer and BurstCnt==MaxBurst-1 (the last word of the burst);
  - (b) srcACK[Owner]==0.
- On release, re-arbitrate in the same cycle using the round-robin pick from Owner+1:
  - Exclude Owner only for condition (b).
  - If a candidate is found: Owner=pick, LastIdx=pick, BurstCnt=0, stay in GRANT.
  - If none is found: State=IDLE.
- Queue full (qREQ=0):
  - Owner, BurstCnt and State hold.
  - qACK still mirrors srcACK[Owner].
  - Condition (b) still releases.
- The block never buffers data. It adds no storage between producer and queue.

## Timing
- Reset state (while rst=0, asynchronous):
  - State=IDLE, Owner=0, LastIdx=NumPorts-1 (so port 0 wins first), BurstCnt=0.
  - Outputs: srcREQ=0, qACK=0, qDIN=0, GrantIdx=0, Busy=0.
- Reset deassertion is taken on the next rising clk.
- Reset mid-burst drops the grant immediately. The queue sees qACK=0 in the same cycle.
- Arbitration latency from IDLE:
  - srcACK is sampled at edge N; Busy=1 after edge N.
  - The first transfer is possible in the cycle after edge N.
- Handoff between owners has zero bubble cycles: the new owner is driven in the cycle after the last word of the old owner.
- The path from srcACK/qREQ to srcREQ/qACK is purely combinational. There is no registered handshake, so the queue's registered full flag bounds timing.
- BurstCnt never exceeds MaxBurst-1. For MaxBurst=1, every transfer releases.
- Single active producer with continuous ACK: it is regranted at each burst end, with BurstCnt reset and no bubble.

## Test plan
- **Reset values:** assert rst=0 mid-burst at any cycle -> Busy=0, qACK=0, srcREQ=0, qDIN=0 immediately. After release, ACK on ports 0 and 2 -> port 0 is granted first.
- **Round-robin fairness:** NumPorts=4, MaxBurst=4, all srcACK=1, qREQ=1 for 32 cycles.
  - Grant order is 0,1,2,3,0,...
  - Each owner gets exactly 4 consecutive transfers.
  - No bubble cycles.
- **Early release:** port 1 owns; drop srcACK[1] after 2 words while port 3 is requesting -> port 3 is owner the next cycle, BurstCnt=0.
- **Queue full stall:** mid-burst of port 2 after word 1, hold qREQ=0 for 5 cycles -> srcREQ[2]=0, Owner and BurstCnt hold. On resume, exactly 3 more words transfer, then release.
- **Single requester:** only srcACK[3]=1, data 0xA0..0xA9, qREQ=1 -> the queue receives all 10 words in order and GrantIdx stays 3.
- **Idle return:** the last requester drops ACK -> Busy=0 the next cycle. A new ACK on port 1 -> Busy=1 after one edge.

Source files
------------

// File: rtl/queue_arbiter.sv
// queue_arbiter: round-robin burst arbiter sharing one queue write port among NumPorts producers.
//   clk      : clock, rising edge
//   rst      : asynchronous active-low reset
//   srcACK   : per-producer word valid
//   srcDIN   : producer data, port i at [i*BitWidth +: BitWidth]
//   srcREQ   : per-producer word accepted (owner only, mirrors qREQ)
//   qREQ     : queue has space
//   qACK     : word valid to queue
//   qDIN     : word to queue
//   GrantIdx : current owner index (0 when idle)
//   Busy     : an owner is granted
module queue_arbiter #(
    parameter int BitWidth = 32,
    parameter int NumPorts = 4,
    parameter int MaxBurst = 4,
    localparam int IW = (NumPorts > 1) ? $clog2(NumPorts) : 1,
    localparam int CW = $clog2(MaxBurst + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NumPorts-1:0]          srcACK,
    input  logic [NumPorts*BitWidth-1:0] srcDIN,
    output logic [NumPorts-1:0]          srcREQ,
    input  logic                         qREQ,
    output logic                         qACK,
    output logic [BitWidth-1:0]          qDIN,
    output logic [IW-1:0]                GrantIdx,
    output logic                         Busy
);
    typedef enum logic {IDLE, GRANT} state_t;

    state_t              state;
    logic [IW-1:0]       owner;
    logic [IW-1:0]       last_idx;
    logic [CW-1:0]       burst_cnt;
    logic [IW-1:0]       base;
    logic [IW-1:0]       pick;
    logic [IW:0]         sum;
    logic [2*NumPorts-1:0] sh;
    logic [NumPorts-1:0] rot;
    logic                found;
    logic                own_ack;
    logic                xfer;
    logic                rel;

    // Rotate requests so bit 0 is the port after base; the lowest set bit wins.
    // base itself lands at the top bit, making it the final candidate. When the
    // owner releases by dropping ACK it is excluded naturally since its bit is 0.
    always_comb begin
        base  = (state == GRANT) ? owner : last_idx;
        sh    = {srcACK, srcACK} >> ({1'b0, base} + (IW+1)'(1));
        rot   = sh[NumPorts-1:0];
        found = 1'b0;
        sum   = '0;
        for (int j = NumPorts - 1; j >= 0; j--) begin
            if (rot[j]) begin
                found = 1'b1;
                sum   = {1'b0, base} + (IW+1)'(j + 1);
            end
        end
        pick = (sum >= (IW+1)'(NumPorts)) ? IW'(sum - (IW+1)'(NumPorts)) : IW'(sum);
    end

    always_comb begin
        srcREQ = '0;
        qACK   = 1'b0;
        qDIN   = '0;
        for (int i = 0; i < NumPorts; i++) begin
            if (state == GRANT && owner == IW'(i)) begin
                srcREQ[i] = qREQ;
                qACK      = srcACK[i];
                qDIN      = srcDIN[i*BitWidth +: BitWidth];
            end
        end
    end

    assign own_ack  = srcACK[owner];
    assign xfer     = (state == GRANT) && qREQ && own_ack;
    assign rel      = !own_ack || (xfer && burst_cnt == CW'(MaxBurst - 1));
    assign Busy     = (state == GRANT);
    assign GrantIdx = (state == GRANT) ? owner : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            owner     <= '0;
            last_idx  <= IW'(NumPorts - 1);
            burst_cnt <= '0;
        end else if (state == IDLE) begin
            if (found) begin
                state     <= GRANT;
                owner     <= pick;
                last_idx  <= pick;
                burst_cnt <= '0;
            end
        end else if (rel) begin
            if (found) begin
                owner     <= pick;
                last_idx  <= pick;
                burst_cnt <= '0;
            end else begin
                state <= IDLE;
            end
        end else if (xfer) begin
            burst_cnt <= burst_cnt + CW'(1);
        end
    end
endmodule

// File: tb/tb_queue_arbiter.sv
// tb_queue_arbiter: scoreboard bench for queue_arbiter against a per-cycle reference model.
module tb_queue_arbiter;
    localparam int W  = 32;
    localparam int N  = 4;
    localparam int MB = 4;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   src_ack = '0;
    logic [N*W-1:0] src_din = '0;
    logic [N-1:0]   src_req;
    logic           q_req = 1'b0;
    logic           q_ack;
    logic [W-1:0]   q_din;
    logic [IW-1:0]  grant_idx;
    logic           busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic         busy;
        logic         qack;
        logic [N-1:0] req;
        int           owner;
    } cyc_t;

    typedef struct {
        int           port;
        logic [W-1:0] data;
    } xfr_t;

    cyc_t cq[$];
    xfr_t xq[$];

    int m_busy, m_owner, m_cnt, m_last;

    queue_arbiter #(.BitWidth(W), .NumPorts(N), .MaxBurst(MB)) dut (
        .clk(clk), .rst(rst), .srcACK(src_ack), .srcDIN(src_din), .srcREQ(src_req),
        .qREQ(q_req), .qACK(q_ack), .qDIN(q_din), .GrantIdx(grant_idx), .Busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // First requesting port after base, wrapping, base itself last; -1 if none.
    function automatic int rr_pick(input int base, input logic [N-1:0] a);
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (base + k) % N;
            if (a[IW'(i)]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy  = 0;
        m_owner = 0;
        m_cnt   = 0;
        m_last  = N - 1;
    endtask

    // Drive one cycle of stimulus, record expectations, advance the model.
    task automatic apply(input logic [N-1:0] ack, input logic qr);
        cyc_t c;
        xfr_t x;
        int   p;
        logic own;
        src_ack = ack;
        q_req   = qr;
        for (int i = 0; i < N; i++) src_din[i*W +: W] = $urandom();
        own     = m_busy != 0 && ack[IW'(m_owner)];
        c.busy  = m_busy != 0;
        c.qack  = own;
        c.owner = m_owner;
        c.req   = '0;
        if (m_busy != 0) c.req[IW'(m_owner)] = qr;
        cq.push_back(c);
        if (m_busy == 0) begin
            p = rr_pick(m_last, ack);
            if (p >= 0) begin
                m_busy  = 1;
                m_owner = p;
                m_last  = p;
                m_cnt   = 0;
            end
        end else begin
            if (qr && own) begin
                x.port = m_owner;
                x.data = src_din[m_owner*W +: W];
                xq.push_back(x);
                m_cnt++;
            end
            if (!own || m_cnt == MB) begin
                p = rr_pick(m_owner, ack);
                if (p < 0) m_busy = 0;
                else begin
                    m_owner = p;
                    m_last  = p;
                    m_cnt   = 0;
                end
            end
        end
    endtask

    task automatic step(input logic [N-1:0] ack, input logic qr);
        @(posedge clk);
        #1;
        apply(ack, qr);
    endtask

    task automatic check_reset_outputs();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_qack", 64'(q_ack), 64'd0);
        chk("rst_srcreq", 64'(src_req), 64'd0);
        chk("rst_qdin", 64'(q_din), 64'd0);
        chk("rst_grant", 64'(grant_idx), 64'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_reset_outputs();
        src_ack = '0;
        q_req   = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        apply('0, 1'b0);
    endtask

    always @(negedge clk) begin : monitor
        cyc_t c;
        xfr_t x;
        if (rst) begin
            if (cq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL cycle_queue: no expectation recorded");
            end else begin
                c = cq.pop_front();
                chk("busy", 64'(busy), 64'(c.busy));
                chk("qack", 64'(q_ack), 64'(c.qack));
                chk("srcreq", 64'(src_req), 64'(c.req));
                if (c.busy) chk("grant_idx", 64'(grant_idx), 64'(c.owner));
            end
            if (q_ack && q_req) begin
                if (xq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL xfer: unexpected word %0h from port %0d", q_din, grant_idx);
                end else begin
                    x = xq.pop_front();
                    chk("xfer_port", 64'(grant_idx), 64'(x.port));
                    chk("xfer_data", 64'(q_din), 64'(x.data));
                end
            end
        end
    end

    initial begin : stim
        logic [N-1:0] ack;
        model_reset();
        #2;
        check_reset_outputs();
        @(posedge clk);
        #1;
        rst = 1'b1;
        apply(4'b0101, 1'b1);
        repeat (3) step(4'b0101, 1'b1);
        repeat (34) step(4'b1111, 1'b1);
        do_reset();
        step(4'b0010, 1'b1);
        repeat (2) step(4'b1010, 1'b1);
        repeat (3) step(4'b1000, 1'b1);
        repeat (2) step(4'b0100, 1'b1);
        repeat (5) step(4'b0110, 1'b0);
        repeat (5) step(4'b0110, 1'b1);
        repeat (12) step(4'b1000, 1'b1);
        repeat (2) step(4'b0000, 1'b1);
        repeat (3) step(4'b0010, 1'b1);
        do_reset();
        ack = '0;
        for (int n = 0; n < 1500; n++) begin
            ack = ack ^ N'($urandom() & $urandom());
            step(ack, ($urandom_range(0, 3) != 0));
            if (n == 700) do_reset();
        end
        repeat (3) step('0, 1'b0);
        chk("leftover_xfers", 64'(xq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
